// File: rtl/overlay_mixer_pipe.sv
// Two-stage VGA overlay mixer: target boxes, aim crosses, centre crosshair and a lock
// indicator over the background pixel, with per-frame shadowed target data and a lock FSM.
module overlay_mixer_pipe #(
   parameter int NUM_TARGETS   = 16,
   parameter int COORD_W       = 10,
   parameter int CX            = 320,
   parameter int CY            = 240,
   parameter int LOCK_ZONE     = 30,
   parameter int LOCK_FRAMES   = 4,
   parameter int UNLOCK_FRAMES = 8,
   parameter int BLINK_LOG2    = 3,
   parameter int UI_X          = 580,
   parameter int UI_Y          = 30
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             frame_start,
   input  logic                             de_in,
   input  logic                             hsync_in,
   input  logic                             vsync_in,
   input  logic [COORD_W-1:0]               x_pixel,
   input  logic [COORD_W-1:0]               y_pixel,
   input  logic [11:0]                      img_bg,
   input  logic [NUM_TARGETS*COORD_W-1:0]   aim_x_all,
   input  logic [NUM_TARGETS*COORD_W-1:0]   aim_y_all,
   input  logic [NUM_TARGETS-1:0]           aim_detected_all,
   input  logic [NUM_TARGETS*COORD_W-1:0]   box_x_min_all,
   input  logic [NUM_TARGETS*COORD_W-1:0]   box_x_max_all,
   input  logic [NUM_TARGETS*COORD_W-1:0]   box_y_min_all,
   input  logic [NUM_TARGETS*COORD_W-1:0]   box_y_max_all,
   output logic [3:0]                       r_port,
   output logic [3:0]                       g_port,
   output logic [3:0]                       b_port,
   output logic                             de_out,
   output logic                             hsync_out,
   output logic                             vsync_out,
   output logic                             locked_out,
   output logic [$clog2(NUM_TARGETS)-1:0]   lock_idx
);
   localparam int IDX_W   = $clog2(NUM_TARGETS);
   localparam int CNT_MAX = (LOCK_FRAMES > UNLOCK_FRAMES) ? LOCK_FRAMES : UNLOCK_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int SQ_W    = 2 * COORD_W + 1;

   typedef logic [COORD_W-1:0] coord_t;
   typedef logic [SQ_W-1:0]    sq_t;
   typedef enum logic [1:0] {S_IDLE, S_ACQUIRE, S_LOCKED, S_RELEASE} lock_state_t;

   localparam coord_t CX_C   = coord_t'(CX);
   localparam coord_t CY_C   = coord_t'(CY);
   localparam coord_t LZ_C   = coord_t'(LOCK_ZONE);
   localparam coord_t UI_X0  = coord_t'(UI_X);
   localparam coord_t UI_X1  = coord_t'(UI_X + 29);
   localparam coord_t UI_Y0  = coord_t'(UI_Y);
   localparam coord_t UI_Y1  = coord_t'(UI_Y + 29);
   localparam coord_t ARM_C  = coord_t'(5);
   localparam coord_t XH_W   = coord_t'(2);
   localparam coord_t XH_LO  = coord_t'(12);
   localparam coord_t XH_HI  = coord_t'(22);
   localparam sq_t    R2_MAX = sq_t'(36);
   localparam logic [CNT_W-1:0] LOCK_N   = CNT_W'(LOCK_FRAMES);
   localparam logic [CNT_W-1:0] UNLOCK_N = CNT_W'(UNLOCK_FRAMES);

   localparam logic [11:0] C_BLACK  = 12'h000;
   localparam logic [11:0] C_WHITE  = 12'hFFF;
   localparam logic [11:0] C_RED    = 12'hF00;
   localparam logic [11:0] C_GREEN  = 12'h0F0;
   localparam logic [11:0] C_YELLOW = 12'hFF0;

   function automatic logic signed [COORD_W:0] sx(input coord_t v);
      return $signed({1'b0, v});
   endfunction

   // Signed difference keeps aim-5 near the origin from wrapping to the far edge.
   function automatic coord_t absdiff(input coord_t a, input coord_t b);
      logic signed [COORD_W:0] d;
      d = sx(a) - sx(b);
      return d[COORD_W] ? coord_t'(-d) : coord_t'(d);
   endfunction

   logic [NUM_TARGETS*COORD_W-1:0] r_sh_ax, r_sh_ay, r_sh_bx0, r_sh_bx1, r_sh_by0, r_sh_by1;
   logic [NUM_TARGETS-1:0]         r_sh_det;
   logic [NUM_TARGETS-1:0]         w_box_hit, w_aim_hit, w_zone;
   logic [IDX_W-1:0]               w_zone_idx, r_lock_idx;
   logic                           w_in_zone;
   lock_state_t                    r_state, w_state_nxt;
   logic [CNT_W-1:0]               r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [BLINK_LOG2-1:0]          r_frame_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_ax  <= '0;
         r_sh_ay  <= '0;
         r_sh_bx0 <= '0;
         r_sh_bx1 <= '0;
         r_sh_by0 <= '0;
         r_sh_by1 <= '0;
         r_sh_det <= '0;
      end else if (frame_start) begin
         r_sh_ax  <= aim_x_all;
         r_sh_ay  <= aim_y_all;
         r_sh_bx0 <= box_x_min_all;
         r_sh_bx1 <= box_x_max_all;
         r_sh_by0 <= box_y_min_all;
         r_sh_by1 <= box_y_max_all;
         r_sh_det <= aim_detected_all;
      end
   end

   for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_ch
      coord_t w_ax, w_ay, w_bx0, w_bx1, w_by0, w_by1, w_zx, w_zy;
      logic   w_in_x, w_in_y, w_on_x, w_on_y;
      assign w_ax  = r_sh_ax[i*COORD_W +: COORD_W];
      assign w_ay  = r_sh_ay[i*COORD_W +: COORD_W];
      assign w_bx0 = r_sh_bx0[i*COORD_W +: COORD_W];
      assign w_bx1 = r_sh_bx1[i*COORD_W +: COORD_W];
      assign w_by0 = r_sh_by0[i*COORD_W +: COORD_W];
      assign w_by1 = r_sh_by1[i*COORD_W +: COORD_W];
      assign w_in_x = (sx(x_pixel) >= sx(w_bx0)) && (sx(x_pixel) <= sx(w_bx1));
      assign w_in_y = (sx(y_pixel) >= sx(w_by0)) && (sx(y_pixel) <= sx(w_by1));
      assign w_on_x = (x_pixel == w_bx0) || (x_pixel == w_bx1);
      assign w_on_y = (y_pixel == w_by0) || (y_pixel == w_by1);
      assign w_box_hit[i] = r_sh_det[i] && ((w_on_x && w_in_y) || (w_on_y && w_in_x));
      assign w_aim_hit[i] = r_sh_det[i] &&
                            (((y_pixel == w_ay) && (absdiff(x_pixel, w_ax) <= ARM_C)) ||
                             ((x_pixel == w_ax) && (absdiff(y_pixel, w_ay) <= ARM_C)));
      // Zone test looks at the live inputs, not the shadow copy.
      assign w_zx = aim_x_all[i*COORD_W +: COORD_W];
      assign w_zy = aim_y_all[i*COORD_W +: COORD_W];
      assign w_zone[i] = aim_detected_all[i] && (absdiff(w_zx, CX_C) < LZ_C) &&
                         (absdiff(w_zy, CY_C) < LZ_C);
   end

   always_comb begin
      w_zone_idx = '0;
      for (int i = NUM_TARGETS - 1; i >= 0; i--)
         if (w_zone[i]) w_zone_idx = IDX_W'(i);
   end
   assign w_in_zone = |w_zone;
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      if (frame_start) begin
         case (r_state)
            S_IDLE: if (w_in_zone) begin
               w_state_nxt = (LOCK_FRAMES == 1) ? S_LOCKED : S_ACQUIRE;
               w_cnt_nxt   = (LOCK_FRAMES == 1) ? '0 : CNT_W'(1);
            end
            S_ACQUIRE: if (w_in_zone) begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == LOCK_N) begin
                  w_state_nxt = S_LOCKED;
                  w_cnt_nxt   = '0;
               end
            end else begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
            S_LOCKED: if (!w_in_zone) begin
               w_state_nxt = (UNLOCK_FRAMES == 1) ? S_IDLE : S_RELEASE;
               w_cnt_nxt   = (UNLOCK_FRAMES == 1) ? '0 : CNT_W'(1);
            end
            S_RELEASE: if (w_in_zone) begin
               w_state_nxt = S_LOCKED;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = w_cnt_inc;
               if (w_cnt_inc == UNLOCK_N) begin
                  w_state_nxt = S_IDLE;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_frame_cnt <= '0;
         r_lock_idx  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (frame_start) r_frame_cnt <= r_frame_cnt + BLINK_LOG2'(1);
         if (frame_start && w_in_zone) r_lock_idx <= w_zone_idx;
      end
   end

   coord_t w_dx, w_dy;
   sq_t    w_r2;
   logic   w_xh_hit, w_ui_hit, w_ui_icon;
   assign w_dx = absdiff(x_pixel, CX_C);
   assign w_dy = absdiff(y_pixel, CY_C);
   assign w_r2 = sq_t'(w_dx) * sq_t'(w_dx) + sq_t'(w_dy) * sq_t'(w_dy);
   assign w_xh_hit = (w_r2 <= R2_MAX) ||
                     ((w_dx < XH_W) && (w_dy >= XH_LO) && (w_dy <= XH_HI)) ||
                     ((w_dy < XH_W) && (w_dx >= XH_LO) && (w_dx <= XH_HI));
   assign w_ui_hit  = (x_pixel >= UI_X0) && (x_pixel <= UI_X1) &&
                      (y_pixel >= UI_Y0) && (y_pixel <= UI_Y1);
   assign w_ui_icon = w_ui_hit && ((x_pixel == UI_X0) || (x_pixel == UI_X1) ||
                                   (y_pixel == UI_Y0) || (y_pixel == UI_Y1));

   // S1: per-pixel hit flags, background and syncs
   logic [NUM_TARGETS-1:0] r_box_hit_p1, r_aim_hit_p1;
   logic                   r_xh_hit_p1, r_ui_hit_p1, r_ui_icon_p1, r_de_p1, r_hs_p1, r_vs_p1;
   logic [11:0]            r_bg_p1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_box_hit_p1 <= '0;
         r_aim_hit_p1 <= '0;
         r_xh_hit_p1  <= 1'b0;
         r_ui_hit_p1  <= 1'b0;
         r_ui_icon_p1 <= 1'b0;
         r_bg_p1      <= '0;
         r_de_p1      <= 1'b0;
         r_hs_p1      <= 1'b0;
         r_vs_p1      <= 1'b0;
      end else begin
         r_box_hit_p1 <= w_box_hit;
         r_aim_hit_p1 <= w_aim_hit;
         r_xh_hit_p1  <= w_xh_hit;
         r_ui_hit_p1  <= w_ui_hit;
         r_ui_icon_p1 <= w_ui_icon;
         r_bg_p1      <= img_bg;
         r_de_p1      <= de_in;
         r_hs_p1      <= hsync_in;
         r_vs_p1      <= vsync_in;
      end
   end

   logic        w_locked;
   logic [11:0] w_ind_col, w_rgb;
   assign w_locked = (r_state == S_LOCKED) || (r_state == S_RELEASE);

   always_comb begin
      w_ind_col = C_WHITE;
      case (r_state)
         S_ACQUIRE: w_ind_col = r_frame_cnt[BLINK_LOG2-1] ? C_WHITE : C_YELLOW;
         S_LOCKED:  w_ind_col = C_YELLOW;
         S_RELEASE: w_ind_col = C_RED;
         default:   w_ind_col = C_WHITE;
      endcase
      w_rgb = r_bg_p1;
      if (!r_de_p1)            w_rgb = C_BLACK;
      else if (r_ui_hit_p1)    w_rgb = r_ui_icon_p1 ? C_BLACK : w_ind_col;
      else if (r_xh_hit_p1)    w_rgb = w_locked ? C_RED : C_BLACK;
      else if (|r_aim_hit_p1)  w_rgb = C_RED;
      else if (|r_box_hit_p1)  w_rgb = C_GREEN;
   end

   // S2: registered colour and syncs
   logic [11:0] r_rgb_p2;
   logic        r_de_p2, r_hs_p2, r_vs_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rgb_p2 <= '0;
         r_de_p2  <= 1'b0;
         r_hs_p2  <= 1'b0;
         r_vs_p2  <= 1'b0;
      end else begin
         r_rgb_p2 <= w_rgb;
         r_de_p2  <= r_de_p1;
         r_hs_p2  <= r_hs_p1;
         r_vs_p2  <= r_vs_p1;
      end
   end

   assign r_port     = r_rgb_p2[11:8];
   assign g_port     = r_rgb_p2[7:4];
   assign b_port     = r_rgb_p2[3:0];
   assign de_out     = r_de_p2;
   assign hsync_out  = r_hs_p2;
   assign vsync_out  = r_vs_p2;
   assign locked_out = w_locked;
   assign lock_idx   = r_lock_idx;
endmodule
